// File: rtl/capture_sequencer.sv
// SPI command controller: holds param/mode, sequences two-channel bit capture
// into a byte buffer and streams responses back with a fixed 2-cycle latency.
module capture_sequencer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_ss,
  input  logic       spi_valid,
  input  logic [7:0] spi_data,
  input  logic       sig0,
  input  logic       sig1,
  output logic [7:0] tx_byte,
  output logic       tx_dv,
  output logic [7:0] param,
  output logic       mode,
  output logic       capturing,
  output logic       done
);

  typedef enum logic [2:0] {CMD, WPARAM, WMODE, ECHO, READ} cmd_state_e;
  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} cap_state_e;

  localparam logic [AW:0]   RD_END  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   RD_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] WR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WR_ONE  = AW'(1);

  cmd_state_e  cmd_state_q;
  cap_state_e  cap_state_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [7:0]    dec_q;
  logic [5:0]    pack_q;
  logic [1:0]    pcnt_q;
  logic          sig0_q, sig0_prev_q, sig1_q;
  logic          resp_vld_q, resp_ram_q;
  logic [7:0]    resp_imm_q;
  logic [7:0]    tx_byte_q;
  logic          tx_dv_q;
  logic [7:0]    param_q;
  logic          mode_q;
  logic [7:0]    mem_rd_q;
  logic [7:0]    mem [DEPTH];

  logic          byte_rx, cmd_byte, arm, busy, rd_start, read_req;
  logic          edge_rise, sample, mem_we;
  logic [AW:0]   rd_cur;
  logic [7:0]    mem_wdata;

  assign byte_rx   = spi_valid && !spi_ss;
  assign cmd_byte  = byte_rx && (cmd_state_q == CMD);
  assign arm       = cmd_byte && (spi_data == 8'h59);
  assign rd_start  = cmd_byte && (spi_data == 8'h57);
  assign read_req  = rd_start || (byte_rx && (cmd_state_q == READ));
  assign busy      = (cap_state_q == ARMED) || (cap_state_q == CAPT);
  assign rd_cur    = rd_start ? '0 : rd_ptr_q;
  assign edge_rise = sig0_q && !sig0_prev_q;
  // The edge cycle's pair is sample 0; afterwards the decimation counter paces samples.
  assign sample    = ((cap_state_q == ARMED) && mode_q && edge_rise) ||
                     ((cap_state_q == CAPT) && (dec_q == 8'd0));
  assign mem_we    = sample && (pcnt_q == 2'd3) && !arm;
  assign mem_wdata = {pack_q, sig0_q, sig1_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_state_q <= CMD;
      cap_state_q <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dec_q       <= 8'd0;
      pack_q      <= 6'd0;
      pcnt_q      <= 2'd0;
      sig0_q      <= 1'b0;
      sig0_prev_q <= 1'b0;
      sig1_q      <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_ram_q  <= 1'b0;
      resp_imm_q  <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      param_q     <= 8'h00;
      mode_q      <= 1'b0;
    end else begin
      sig0_q      <= sig0;
      sig0_prev_q <= sig0_q;
      sig1_q      <= sig1;

      tx_dv_q <= resp_vld_q;
      if (resp_vld_q) tx_byte_q <= resp_ram_q ? mem_rd_q : resp_imm_q;
      resp_vld_q <= 1'b0;
      resp_ram_q <= 1'b0;

      if (spi_ss) begin
        cmd_state_q <= CMD;
      end else if (spi_valid) begin
        unique case (cmd_state_q)
          CMD: begin
            case (spi_data)
              8'h55: cmd_state_q <= WPARAM;
              8'h56: cmd_state_q <= ECHO;
              8'h57: cmd_state_q <= READ;
              8'h58: cmd_state_q <= WMODE;
              8'h5A: begin
                resp_vld_q <= 1'b1;
                resp_imm_q <= {cap_state_q == CAPT, cap_state_q == ARMED,
                               cap_state_q == DONE, mode_q, 4'h0};
              end
              default: ;
            endcase
          end
          WPARAM: begin
            param_q     <= spi_data;
            cmd_state_q <= CMD;
          end
          WMODE: begin
            mode_q      <= spi_data[7];
            cmd_state_q <= CMD;
          end
          ECHO: begin
            resp_vld_q <= 1'b1;
            resp_imm_q <= spi_data;
          end
          READ: ;
          default: cmd_state_q <= CMD;
        endcase
      end

      // The READ command byte itself preloads mem[0]; each later byte returns the next entry.
      if (read_req) begin
        resp_vld_q <= 1'b1;
        if (busy) begin
          resp_imm_q <= 8'hEE;
          rd_ptr_q   <= rd_cur;
        end else if (rd_cur == RD_END) begin
          resp_imm_q <= 8'hFF;
        end else begin
          resp_ram_q <= 1'b1;
          rd_ptr_q   <= rd_cur + RD_ONE;
        end
      end

      if (arm) begin
        cap_state_q <= ARMED;
        wr_ptr_q    <= '0;
        pack_q      <= 6'd0;
        pcnt_q      <= 2'd0;
        dec_q       <= 8'd0;
      end else begin
        unique case (cap_state_q)
          ARMED: begin
            if (!mode_q) begin
              cap_state_q <= CAPT;
            end else if (edge_rise) begin
              cap_state_q <= CAPT;
              dec_q       <= param_q;
            end
          end
          CAPT: dec_q <= (dec_q == 8'd0) ? param_q : dec_q - 8'd1;
          default: ;
        endcase
        if (sample) begin
          pack_q <= {pack_q[3:0], sig0_q, sig1_q};
          pcnt_q <= pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            wr_ptr_q <= wr_ptr_q + WR_ONE;
            if (wr_ptr_q == WR_LAST) cap_state_q <= DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
    mem_rd_q <= mem[rd_cur[AW-1:0]];
  end

  assign tx_byte   = tx_byte_q;
  assign tx_dv     = tx_dv_q;
  assign param     = param_q;
  assign mode      = mode_q;
  assign capturing = (cap_state_q == CAPT);
  assign done      = (cap_state_q == DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer (DEPTH=16): register writes, echo,
// immediate and edge-triggered capture, read-back, busy/abort/reset cases.
module tb_capture_sequencer;

  logic       clk = 1'b0;
  logic       rst, spi_ss, spi_valid, sig0, sig1;
  logic [7:0] spi_data;
  logic [7:0] tx_byte, param;
  logic       tx_dv, mode, capturing, done;

  int n_tests = 0;
  int n_fail  = 0;

  capture_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .spi_ss(spi_ss), .spi_valid(spi_valid),
    .spi_data(spi_data), .sig0(sig0), .sig1(sig1), .tx_byte(tx_byte),
    .tx_dv(tx_dv), .param(param), .mode(mode), .capturing(capturing), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    spi_valid = 1'b1;
    spi_data  = b;
    tick();
    spi_valid = 1'b0;
  endtask

  task automatic send_nores(input string tag, input logic [7:0] b);
    logic seen;
    send(b);
    seen = tx_dv;
    tick(); seen |= tx_dv;
    tick(); seen |= tx_dv;
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  // Response must appear exactly two cycles after the edge that samples spi_valid.
  task automatic send_expect(input string tag, input logic [7:0] b, input logic [7:0] exp);
    send(b);
    chk({tag, "_early"}, {31'd0, tx_dv}, 32'd0);
    tick();
    chk(tag, {23'd0, tx_dv, tx_byte}, {23'd0, 1'b1, exp});
  endtask

  initial begin
    int  cnt;
    bit  fin;
    bit  seen_cap;
    rst = 1'b1; spi_ss = 1'b1; spi_valid = 1'b0; spi_data = 8'h00;
    sig0 = 1'b0; sig1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_outputs", {tx_byte, tx_dv, param, mode, capturing, done},
        {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

    // Register writes
    spi_ss = 1'b0;
    send_nores("wparam_cmd", 8'h55);
    send_nores("wparam_dat", 8'h03);
    spi_ss = 1'b1; tick();
    chk("param_03", {24'd0, param}, 32'h03);
    spi_ss = 1'b0;
    send_nores("wmode_cmd", 8'h58);
    send_nores("wmode_dat", 8'h80);
    spi_ss = 1'b1; tick();
    chk("mode_1", {31'd0, mode}, 32'd1);

    // Echo
    spi_ss = 1'b0;
    send_nores("echo_cmd", 8'h56);
    send_expect("echo_12", 8'h12, 8'h12);
    send_expect("echo_34", 8'h34, 8'h34);
    spi_ss = 1'b1; tick();

    // Aborted write: the byte after SS high lands in CMD and is ignored
    spi_ss = 1'b0;
    send(8'h55);
    spi_ss = 1'b1; tick();
    spi_ss = 1'b0;
    send_nores("abort_ignored", 8'h77);
    spi_ss = 1'b1; tick();
    chk("abort_param", {24'd0, param}, 32'h03);

    // param=0, mode=0, idle status
    spi_ss = 1'b0;
    send(8'h55); send(8'h00);
    send(8'h58); send(8'h00);
    send_expect("status_idle", 8'h5A, 8'h00);
    chk("param_mode_0", {23'd0, mode, param}, 32'h0);

    // Immediate capture: pairs (1,0) pack to 0xAA, 64 samples at one per clock
    sig0 = 1'b1; sig1 = 1'b0;
    send(8'h59);
    cnt = 0; fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      tick();
      if (capturing) cnt++;
      if (done) fin = 1'b1;
    end
    chk("imm_done", {31'd0, fin}, 32'd1);
    chk("imm_capt_cycles", cnt, 64);
    chk("imm_capt_low", {31'd0, capturing}, 32'd0);
    send_expect("status_done", 8'h5A, 8'h20);
    spi_ss = 1'b1; tick();

    spi_ss = 1'b0;
    send_expect("imm_rd0", 8'h57, 8'hAA);
    for (int i = 1; i < 16; i++) send_expect($sformatf("imm_rd%0d", i), 8'h00, 8'hAA);
    send_expect("imm_rd_end0", 8'h00, 8'hFF);
    send_expect("imm_rd_end1", 8'h00, 8'hFF);
    spi_ss = 1'b1; tick();

    // Edge trigger, param=1: square wave 2 high/2 low sampled every 2 clocks
    // gives pairs (1,1),(0,1),(1,1),(0,1) -> 0xDD. Sample 0 is taken in ARMED,
    // the remaining 63 samples take 126 clocks in CAPT.
    sig0 = 1'b0; sig1 = 1'b1;
    spi_ss = 1'b0;
    send(8'h55); send(8'h01);
    send(8'h58); send(8'h80);
    send(8'h59);
    chk("arm_clears_done", {31'd0, done}, 32'd0);
    send_expect("status_armed", 8'h5A, 8'h50);
    seen_cap = 1'b0;
    for (int i = 0; i < 44; i++) begin
      tick();
      seen_cap |= capturing;
    end
    chk("no_capt_before_edge", {31'd0, seen_cap | done}, 32'd0);
    cnt = 0; fin = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      sig0 = ((k % 4) < 2);
      tick();
      if (capturing) cnt++;
      if (done) fin = 1'b1;
    end
    chk("edge_done", {31'd0, fin}, 32'd1);
    chk("edge_capt_cycles", cnt, 126);
    spi_ss = 1'b1; tick();
    spi_ss = 1'b0;
    send_expect("edge_rd0", 8'h57, 8'hDD);
    for (int i = 1; i < 16; i++) send_expect($sformatf("edge_rd%0d", i), 8'h00, 8'hDD);
    send_expect("edge_rd_end", 8'h00, 8'hFF);
    spi_ss = 1'b1; tick();

    // Read rejected while capturing (slow capture, param=0xFF)
    spi_ss = 1'b0;
    send(8'h55); send(8'hFF);
    send(8'h58); send(8'h00);
    send(8'h59);
    send_expect("busy_rd_cmd", 8'h57, 8'hEE);
    send_expect("busy_rd_dat", 8'h00, 8'hEE);
    spi_ss = 1'b1; tick();
    spi_ss = 1'b0;
    send_expect("status_capt", 8'h5A, 8'h80);
    chk("capt_active", {31'd0, capturing}, 32'd1);
    spi_ss = 1'b1; tick();

    // Reset mid-capture
    rst = 1'b1;
    tick();
    chk("rst_mid_capt", {22'd0, capturing, done, tx_byte},
        {22'd0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    tick();
    chk("rst_param", {23'd0, mode, param}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
